// File: rtl/exu_muldiv_seq.sv
// exu_muldiv_seq: sequential RISC-V M-extension multiply/divide (shift-add multiply, restoring divide).
// Optional macro EXU_MULDIV_FAST_MUL_EN selects a single-cycle registered multiply; divides always iterate.
module exu_muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_is_word,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam int CNT_W = $clog2(XLEN);

  // Replace bits above 31 with bit 31 (sgn=1) or zero (sgn=0).
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = (i < 32) ? v[i] : (sgn & v[31]);
    end
    return r;
  endfunction

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  hi_reg, lo_reg, opd_reg;
  logic [2:0]       op_reg;
  logic             word_reg, qneg_reg, rneg_reg;
  logic [XLEN-1:0]  result_reg;
  logic [TAG_W-1:0] tag_reg;

  logic             accept, last;
  logic             is_div, word_req, ext_sgn, sgn_op1, sgn_op2, neg1, neg2;
  logic             div_zero, div_ovf;
  logic [XLEN-1:0]  src1_x, src2_x, mag1, mag2, special_raw, special_res;
  logic             take_direct;
  logic [XLEN-1:0]  direct_res;

  logic [XLEN:0]    mul_sum, div_shift, div_diff;
  logic             div_fit;
  logic [XLEN-1:0]  step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_sgn;
  logic [XLEN-1:0]  quot, remd, raw_res, final_res;

  assign accept = (state_reg == S_IDLE) && req_valid && !flush;
  assign last   = (cnt_reg == CNT_W'(XLEN - 1));

  always_comb begin
    is_div   = req_op[2];
    word_req = (XLEN == 64) && req_is_word;
    ext_sgn  = !((req_op == OP_DIVU) || (req_op == OP_REMU));
    src1_x   = word_req ? ext32(req_src1, ext_sgn) : req_src1;
    src2_x   = word_req ? ext32(req_src2, ext_sgn) : req_src2;
    sgn_op1  = (req_op == OP_MULH) || (req_op == OP_MULHSU) || (req_op == OP_DIV) || (req_op == OP_REM);
    sgn_op2  = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
    neg1     = sgn_op1 & src1_x[XLEN-1];
    neg2     = sgn_op2 & src2_x[XLEN-1];
    mag1     = neg1 ? -src1_x : src1_x;
    mag2     = neg2 ? -src2_x : src2_x;

    // Corner cases are resolved at accept and never enter the iterative datapath.
    div_zero = is_div && (src2_x == '0);
    div_ovf  = is_div && sgn_op2 && (src1_x == {1'b1, {(XLEN-1){1'b0}}}) && (src2_x == '1);
    if (div_zero) begin
      special_raw = req_op[1] ? src1_x : '1;
    end else begin
      special_raw = req_op[1] ? '0 : src1_x;
    end
    special_res = word_req ? ext32(special_raw, 1'b1) : special_raw;
  end

`ifdef EXU_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
  logic [XLEN-1:0]   fast_raw, fast_res;

  always_comb begin
    fast_a   = {{XLEN{neg1}}, src1_x};
    fast_b   = {{XLEN{neg2}}, src2_x};
    fast_p   = fast_a * fast_b;
    fast_raw = (req_op[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    fast_res = word_req ? ext32(fast_raw, 1'b1) : fast_raw;
  end

  assign take_direct = div_zero | div_ovf | !is_div;
  assign direct_res  = is_div ? special_res : fast_res;
`else
  assign take_direct = div_zero | div_ovf;
  assign direct_res  = special_res;
`endif

  // One iteration: multiply shifts the {hi,lo} product right, divide shifts the remainder left.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opd_reg} : {(XLEN+1){1'b0}});
    div_shift = {hi_reg, lo_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, opd_reg};
    div_fit   = ~div_diff[XLEN];
    if (op_reg[2]) begin
      step_hi = div_fit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo = {lo_reg[XLEN-2:0], div_fit};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {step_hi, step_lo};
    prod_sgn = qneg_reg ? -prod : prod;
    quot     = qneg_reg ? -step_lo : step_lo;
    remd     = rneg_reg ? -step_hi : step_hi;
    if (op_reg[2]) begin
      raw_res = op_reg[1] ? remd : quot;
    end else if (op_reg[1:0] == 2'b00) begin
      raw_res = prod_sgn[XLEN-1:0];
    end else begin
      raw_res = prod_sgn[2*XLEN-1:XLEN];
    end
    final_res = word_reg ? ext32(raw_res, 1'b1) : raw_res;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = take_direct ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_next = S_IDLE;
        end else if (last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opd_reg    <= '0;
      op_reg     <= '0;
      word_reg   <= 1'b0;
      qneg_reg   <= 1'b0;
      rneg_reg   <= 1'b0;
      result_reg <= '0;
      tag_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg   <= req_op;
        word_reg <= word_req;
        tag_reg  <= req_tag;
        qneg_reg <= neg1 ^ neg2;
        rneg_reg <= neg1;
        cnt_reg  <= '0;
        hi_reg   <= '0;
        lo_reg   <= is_div ? mag1 : mag2;
        opd_reg  <= is_div ? mag2 : mag1;
        if (take_direct) begin
          result_reg <= direct_res;
        end
      end else if ((state_reg == S_BUSY) && !flush) begin
        cnt_reg <= cnt_reg + 1'b1;
        hi_reg  <= step_hi;
        lo_reg  <= step_lo;
        if (last) begin
          result_reg <= final_res;
        end
      end
    end
  end

  assign req_ready   = (state_reg == S_IDLE);
  assign resp_valid  = (state_reg == S_DONE) && !flush;
  assign resp_result = result_reg;
  assign resp_tag    = tag_reg;

endmodule

// File: tb/tb_exu_muldiv_seq.sv
// Bench for exu_muldiv_seq (XLEN=64): arithmetic reference model, scoreboard, directed vectors.
module tb_exu_muldiv_seq;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_is_word = 1'b0;
  logic        resp_ready = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [63:0] req_src1 = 64'd0;
  logic [63:0] req_src2 = 64'd0;
  logic [5:0]  req_tag = 6'd0;
  logic        req_ready, resp_valid;
  logic [63:0] resp_result;
  logic [5:0]  resp_tag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    logic [5:0]  tag;
    int          due;
  } exp_t;
  exp_t sb[$];
  bit head_seen = 1'b0;

  exu_muldiv_seq #(.XLEN(64), .TAG_W(6)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_is_word (req_is_word),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .req_tag     (req_tag),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_tag    (resp_tag)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ext_operand(input logic [2:0] op, input logic w, input logic [63:0] v);
    if (!w) return v;
    if (op == 3'd5 || op == 3'd7) return {32'h0, v[31:0]};
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] model_res(input logic [2:0] op, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y, r;
    logic signed [63:0] sx, sy, sq;
    logic [127:0] xs, xu, ys, yu, p;
    logic ovf;
    x = ext_operand(op, w, a);
    y = ext_operand(op, w, b);
    sx = x;
    sy = y;
    xs = {{64{x[63]}}, x};
    xu = {64'h0, x};
    ys = {{64{y[63]}}, y};
    yu = {64'h0, y};
    ovf = (x == MIN64) && (y == ONES);
    r = 64'd0;
    case (op)
      3'd0: begin p = xu * yu; r = p[63:0]; end
      3'd1: begin p = xs * ys; r = p[127:64]; end
      3'd2: begin p = xs * yu; r = p[127:64]; end
      3'd3: begin p = xu * yu; r = p[127:64]; end
      3'd4: begin
        if (y == 64'd0) r = ONES;
        else if (ovf) r = x;
        else begin sq = sx / sy; r = sq; end
      end
      3'd5: r = (y == 64'd0) ? ONES : x / y;
      3'd6: begin
        if (y == 64'd0) r = x;
        else if (ovf) r = 64'd0;
        else begin sq = sx % sy; r = sq; end
      end
      default: r = (y == 64'd0) ? x : x % y;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  // Cycles from accept edge until resp_valid is first seen (1 = right after the accept edge).
  function automatic int model_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y;
    x = ext_operand(op, w, a);
    y = ext_operand(op, w, b);
    if (op[2]) begin
      if (y == 64'd0) return 1;
      if ((op == 3'd4 || op == 3'd6) && x == MIN64 && y == ONES) return 1;
      return 65;
    end
`ifdef EXU_MULDIV_FAST_MUL_EN
    return 1;
`else
    return 65;
`endif
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_resp got=valid result=0x%h exp=no_response", resp_result);
        end else begin
          chk("resp_result", resp_result, sb[0].res);
          chk("resp_tag", 64'(resp_tag), 64'(sb[0].tag));
          chk("req_ready_in_done", 64'(req_ready), 64'd0);
          if (!head_seen) begin
            chk("resp_latency_cycle", 64'(cyc), 64'(sb[0].due));
            head_seen = 1'b1;
          end
          if (resp_ready) begin
            $display("resp tag=%0d result=0x%h cycle=%0d", resp_tag, resp_result, cyc);
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
      end else if (sb.size() != 0 && !head_seen && cyc >= sb[0].due) begin
        checks++;
        failures++;
        $display("FAIL resp_late got=no_valid exp=valid_by_cycle_%0d", sb[0].due);
        head_seen = 1'b1;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] tag, input logic [63:0] lit, input bit push, output int acc);
    int n;
    logic [63:0] m;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op = op;
    req_is_word = w;
    req_src1 = a;
    req_src2 = b;
    req_tag = tag;
    @(posedge clock); #1;
    acc = cyc;
    req_valid = 1'b0;
    m = model_res(op, w, a, b);
    chk("model_pin", m, lit);
    if (push) sb.push_back('{res: m, tag: tag, due: cyc + model_lat(op, w, a, b) - 1});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d_pending exp=0_pending", sb.size());
      sb.delete();
      head_seen = 1'b0;
    end
  endtask

  task automatic run(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                     input logic [5:0] tag, input logic [63:0] lit);
    int acc;
    issue(op, w, a, b, tag, lit, 1'b1, acc);
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2, n;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_resp_result", resp_result, 64'd0);
    chk("reset_resp_tag", 64'(resp_tag), 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b1;

    run(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 6'd5, 64'hFFFF_FFFF_FFFF_FFEB);
    run(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 6'd6, 64'hFFFF_FFFF_FFFF_FFFA);
    run(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 6'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    run(3'd5, 1'b0, 64'd20, 64'd0, 6'd8, ONES);
    run(3'd7, 1'b0, 64'd20, 64'd0, 6'd9, 64'd20);
    run(3'd4, 1'b0, MIN64, ONES, 6'd10, MIN64);
    run(3'd6, 1'b0, MIN64, ONES, 6'd11, 64'd0);
    run(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 6'd12, 64'hFFFF_FFFF_8000_0000);
    run(3'd2, 1'b0, ONES, 64'd2, 6'd13, ONES);
    run(3'd3, 1'b0, ONES, ONES, 6'd14, 64'hFFFF_FFFF_FFFF_FFFE);
    run(3'd0, 1'b1, 64'h0000_0001_0000_0002, 64'd3, 6'd15, 64'd6);
    run(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 6'd16, ONES);
    run(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 6'd17, ONES);
    run(3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 6'd18, 64'h0000_0000_7FFF_FFFF);
    run(3'd4, 1'b1, 64'd5, 64'd0, 6'd19, ONES);
    run(3'd5, 1'b0, 64'd256, 64'd16, 6'd20, 64'd16);
    run(3'd3, 1'b0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 6'd21, 64'd1);
    run(3'd6, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFF9, 6'd22, 64'd6);
    run(3'd4, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFF9, 6'd23, 64'hFFFF_FFFF_FFFF_FFFE);

    // Stall in DONE for 10 cycles, then release.
    resp_ready = 1'b0;
    issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 6'd33, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, a1);
    n = 0;
    while (!head_seen && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("stall_resp_seen", 64'(head_seen), 64'd1);
    repeat (10) begin
      @(posedge clock); #1;
      chk("stall_resp_valid", 64'(resp_valid), 64'd1);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_consume", 64'(req_ready), 64'd1);
    chk("stall_consumed", 64'(sb.size()), 64'd0);
    sb.delete();
    head_seen = 1'b0;

    // Back-to-back throughput.
    issue(3'd5, 1'b0, 64'd100, 64'd7, 6'd40, 64'd14, 1'b1, a1);
    issue(3'd7, 1'b0, 64'd100, 64'd7, 6'd41, 64'd2, 1'b1, a2);
    chk("throughput_cycles", 64'(a2 - a1), 64'd66);
    drain();

    // Flush while DONE is stalled.
    resp_ready = 1'b0;
    issue(3'd5, 1'b0, 64'd20, 64'd0, 6'd42, ONES, 1'b1, a1);
    @(posedge clock); #1;
    flush = 1'b1;
    #1;
    chk("flush_done_valid", 64'(resp_valid), 64'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_done_ready", 64'(req_ready), 64'd1);
    sb.delete();
    head_seen = 1'b0;
    resp_ready = 1'b1;

    // Flush on BUSY cycle 20: no response may ever appear.
    issue(3'd5, 1'b0, 64'd1000, 64'd3, 6'd43, 64'd333, 1'b0, a1);
    repeat (19) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_busy_ready", 64'(req_ready), 64'd1);
    repeat (70) @(posedge clock);
    #1;
    run(3'd5, 1'b0, 64'd100, 64'd7, 6'd44, 64'd14);

    // Flush coincident with a request: must not be accepted.
    req_valid = 1'b1;
    req_op = 3'd5;
    req_src1 = 64'd9;
    req_src2 = 64'd0;
    req_tag = 6'd50;
    flush = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    flush = 1'b0;
    chk("flush_req_rejected", 64'(req_ready), 64'd1);
    repeat (3) @(posedge clock);
    #1;

    // Asynchronous reset mid-operation.
    issue(3'd5, 1'b0, 64'd1000, 64'd3, 6'd45, 64'd333, 1'b0, a1);
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_req_ready", 64'(req_ready), 64'd1);
    chk("midreset_resp_valid", 64'(resp_valid), 64'd0);
    chk("midreset_resp_result", resp_result, 64'd0);
    chk("midreset_resp_tag", 64'(resp_tag), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 6'd46, 64'hFFFF_FFFF_FFFF_FFFA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_muldiv_seq.md
# exu_muldiv_seq

Sequential, parametrised multiply/divide unit for the backend execute stage, replacing the single-cycle combinational muldiv path. Accepts one RISC-V M-extension operation through a valid/ready handshake, iterates shift-add multiply or restoring divide over XLEN cycles, and returns the result with its tag. Handles RV64 word variants, the RISC-V divide-by-zero and overflow cases, and pipeline flush.

## Interface
- XLEN, 64: operand/result width; 32 or 64. Word ops exist only when XLEN=64.
- TAG_W, 6: width of the opaque tag (ROB index) carried with each operation.

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  kill in-flight operation; return to IDLE
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_is_word  in  1  W-variant (MULW/DIVW/DIVUW/REMW/REMUW); ignored when XLEN=32
- req_src1, req_src2  in  XLEN  rs1 / rs2 operand values
- req_tag  in  TAG_W  tag
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_result  out  XLEN  result
- resp_tag  out  TAG_W  tag of the returned result

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE; req_ready=1, resp_valid=0, resp_result=0, resp_tag=0, iteration counter=0.
- IDLE: req_valid&req_ready&~flush latches op, operands, tag. Special case -> DONE directly; otherwise -> BUSY, counter=0.
- Special cases (decided at accept, divide ops only): divisor==0 -> quotient all ones, remainder = dividend; signed dividend==most-negative and divisor==-1 -> quotient = dividend, remainder 0. Evaluated on the (word-extended) operands.
- Word ops: operands sign-extended (DIVW/REMW/MULW) or zero-extended (DIVUW/REMUW) from bits [31:0] to XLEN, computed at full width; final result = sign-extension of bits [31:0].
- Multiply: 2·XLEN-bit shift-add on magnitudes, sign applied at end per op signedness (MULHSU: src1 signed, src2 unsigned). MUL returns low XLEN bits; MULH* return high XLEN bits.
- Divide: restoring radix-2 on magnitudes, one quotient bit per cycle. Quotient sign = sign1^sign2; remainder sign = dividend sign.
- BUSY: counter increments each cycle; after XLEN iterations -> DONE with result registered.
- DONE: resp_valid = ~flush. resp_valid&resp_ready -> IDLE. Result and tag held stable while stalled.
- flush in any state: next state IDLE, operation discarded; resp_valid low in the flush cycle. Flush coincident with a request: request not accepted.
- No new request accepted in the cycle the response is consumed (req_ready low in DONE).

## Timing
- Accept at edge 0. Normal op: resp_valid high from cycle XLEN+1 (64-bit: 65 cycles). Special case: resp_valid at cycle 1.
- Back-to-back throughput: one op per XLEN+2 cycles with resp_ready held high.
- req_ready is a function of state only; resp_valid depends combinationally on state and flush only; no combinational path from req_* to resp_*.
- reset_n deassertion mid-operation: immediate IDLE, outputs to reset values.

## Configuration
- EXU_MULDIV_FAST_MUL_EN defined: multiply ops use one full-width combinational product, registered; IDLE -> DONE directly, resp_valid at cycle 1. Divides unchanged.
- Undefined: multiply iterates like divide (XLEN+1 cycle latency); no wide multiplier instantiated.

## Test plan
- XLEN=64, MUL 7×(-3), resp_ready=1 -> resp_result=0xFFFF_FFFF_FFFF_FFEB at cycle 65 (cycle 1 with fast-mul), tag echoed.
- DIV -20/3 -> 0xFFFF_FFFF_FFFF_FFFA; REM -20/3 -> 0xFFFF_FFFF_FFFF_FFFE; DIVU 20/0 -> all ones, REMU 20/0 -> 20, both at cycle 1.
- DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, REM -> 0; DIVW 0x8000_0000/0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- MULHSU src1=-1, src2=2 -> 0xFFFF_FFFF_FFFF_FFFF; MULHU all-ones×all-ones -> 0xFFFF_FFFF_FFFF_FFFE; MULW 0x1_0000_0002×3 -> 6.
- resp_ready low 10 cycles in DONE -> resp_valid, result, tag stable, req_ready low; then accepted, next req_ready high.
- flush at BUSY cycle 20 -> resp_valid never asserted, req_ready high next cycle; new DIVU 100/7 -> 14 at cycle 65.
